gowin_tl_rx_adapter: RTL and testbench

//  Sits between the Gowin PCIe controller TL RX port and the RIFFA RX engine in the GW5AST Gen2 x4 top.

---
 rtl/gowin_tl_rx_adapter_pkg.sv | 39 +++
 rtl/gowin_tl_rx_adapter_if.sv | 38 +++
 rtl/gowin_tl_rx_adapter_fifo.sv | 76 +++++++
 rtl/gowin_tl_rx_adapter.sv | 157 +++++++++++++++
 tb/tb_gowin_tl_rx_adapter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gowin_tl_rx_adapter_pkg.sv
// Shared types and helpers for the Gowin TL RX to RIFFA RX adapter.
package gowin_tl_rx_adapter_pkg;

   localparam int GOWIN_DW_PER_BEAT = 8;
   localparam int GOWIN_DATA_W      = 32 * GOWIN_DW_PER_BEAT;

   // One skid FIFO entry; fields listed MSB first.
   typedef struct packed {
      logic [GOWIN_DATA_W-1:0] data;
      logic                    sop;
      logic                    eop;
      logic [2:0]              end_off;
      logic [5:0]              bardec;
      logic                    err;
   } gowin_rx_beat_t;

   // Bit position of eop inside gowin_rx_beat_t (err + bardec + end_off below it).
   localparam int GOWIN_BEAT_EOP_BIT = 10;

   // Index of the highest valid dword in a beat.
   function automatic logic [2:0] mask_to_end_off(input logic [7:0] mask);
      logic [2:0] off;
      off = 3'd0;
      for (int i = 0; i < GOWIN_DW_PER_BEAT; i++) begin
         if (mask[i]) begin
            off = 3'(i);
         end else begin
            off = off;
         end
      end
      return off;
   endfunction

   // A well-formed mask is non-empty and of the form 2**k-1.
   function automatic logic mask_is_contig(input logic [7:0] mask);
      return (mask != 8'h00) && ((mask & (mask + 8'h01)) == 8'h00);
   endfunction

endpackage

// File: rtl/gowin_tl_rx_adapter_if.sv
// Controller-side TL RX stream, RIFFA-side RX_TLP stream and adapter status.
interface gowin_tl_rx_adapter_if;
   import gowin_tl_rx_adapter_pkg::*;

   logic                    tl_rx_sop;
   logic                    tl_rx_eop;
   logic [GOWIN_DATA_W-1:0] tl_rx_data;
   logic [7:0]              tl_rx_valid;
   logic [5:0]              tl_rx_bardec;
   logic [7:0]              tl_rx_err;
   logic                    tl_rx_wait;
   logic [GOWIN_DATA_W-1:0] rx_tlp;
   logic                    rx_tlp_valid;
   logic                    rx_tlp_ready;
   logic                    rx_tlp_start_flag;
   logic [2:0]              rx_tlp_start_offset;
   logic                    rx_tlp_end_flag;
   logic [2:0]              rx_tlp_end_offset;
   logic [5:0]              rx_tlp_bar_decode;
   logic                    rx_tlp_err;
   logic [15:0]             proto_err_cnt;
   logic                    overflow;

   modport slave (
      input  tl_rx_sop, tl_rx_eop, tl_rx_data, tl_rx_valid, tl_rx_bardec, tl_rx_err, rx_tlp_ready,
      output tl_rx_wait, rx_tlp, rx_tlp_valid, rx_tlp_start_flag, rx_tlp_start_offset,
             rx_tlp_end_flag, rx_tlp_end_offset, rx_tlp_bar_decode, rx_tlp_err,
             proto_err_cnt, overflow
   );

   modport master (
      output tl_rx_sop, tl_rx_eop, tl_rx_data, tl_rx_valid, tl_rx_bardec, tl_rx_err, rx_tlp_ready,
      input  tl_rx_wait, rx_tlp, rx_tlp_valid, rx_tlp_start_flag, rx_tlp_start_offset,
             rx_tlp_end_flag, rx_tlp_end_offset, rx_tlp_bar_decode, rx_tlp_err,
             proto_err_cnt, overflow
   );

endinterface

// File: rtl/gowin_tl_rx_adapter_fifo.sv
// First-word-fall-through skid FIFO. mark_last sets one flag bit of the
// newest entry so a truncated TLP can still be closed while it is unread.
module gowin_tl_rx_adapter_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int MARK_BIT   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  mark_last,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                   DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]  CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

   logic [WIDTH-1:0]      mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic                  rd_ok_s;
   logic                  wr_ok_s;
   logic                  mark_ok_s;

   assign empty   = (count_r == CNT_ZERO);
   assign full    = (count_r == CNT_FULL);
   assign count   = count_r;
   assign rd_data = mem_r[rd_ptr_r];

   // A write into a full FIFO only lands when a read frees the slot this cycle;
   // an entry leaving this cycle counts as already delivered and is not patched.
   assign rd_ok_s   = rd_en & ~empty;
   assign wr_ok_s   = wr_en & (~full | rd_ok_s);
   assign mark_ok_s = mark_last & ~empty & ~(rd_ok_s & (count_r == CNT_ONE));

   // Storage array and in-place flag patch of the newest entry.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
      if (mark_ok_s) begin
         mem_r[wr_ptr_r - PTR_ONE][MARK_BIT] <= 1'b1;
      end
   end

   // Pointers wrap naturally; occupancy is one bit wider to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= CNT_ZERO;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/gowin_tl_rx_adapter.sv
// Gowin PCIe TL RX stream to RIFFA RX_TLP adapter: framing FSM, mask decode,
// error accumulation, skid buffering and occupancy-based backpressure.
module gowin_tl_rx_adapter
   import gowin_tl_rx_adapter_pkg::*;
#(
   parameter int C_PCI_DATA_WIDTH  = 256,
   parameter int C_FIFO_DEPTH_LOG2 = 3,
   parameter int C_RX_WAIT_LATENCY = 2
) (
   input  logic                   pcie_tl_clk,
   input  logic                   pcie_tl_rst_n,
   gowin_tl_rx_adapter_if.slave   bus
);

   localparam int                          L            = C_FIFO_DEPTH_LOG2;
   localparam int                          WAIT_THRESH_I = (1 << L) - C_RX_WAIT_LATENCY - 1;
   localparam logic [L:0]                  WAIT_THRESH  = WAIT_THRESH_I[L:0];
   localparam logic [0:0]                  ST_IDLE      = 1'b0;
   localparam logic [0:0]                  ST_IN_PKT    = 1'b1;

   logic [0:0]     state_r, state_nxt_s;
   logic [5:0]     bar_r, bar_nxt_s;
   logic           err_acc_r, err_acc_nxt_s;
   gowin_rx_beat_t wr_beat_s, rd_beat_s;
   logic           beat_s, beat_err_s, wr_en_s, mark_s;
   logic           stray_s, restart_s, noncontig_s;
   logic [1:0]     proto_inc_s;
   logic [16:0]    proto_sum_s;
   logic [15:0]    proto_cnt_r;
   logic           overflow_r, wait_r;
   logic           full_s, empty_s, rd_s, wr_ok_s;
   logic [L:0]     count_s, occ_nxt_s;

   assign beat_s      = (bus.tl_rx_valid != 8'h00);
   assign beat_err_s  = |bus.tl_rx_err;
   assign noncontig_s = wr_en_s & ~mask_is_contig(bus.tl_rx_valid);
   assign proto_inc_s = {1'b0, stray_s} + {1'b0, restart_s} + {1'b0, noncontig_s};
   assign proto_sum_s = {1'b0, proto_cnt_r} + {15'h0000, proto_inc_s};
   assign rd_s        = bus.rx_tlp_ready & ~empty_s;
   assign wr_ok_s     = wr_en_s & (~full_s | rd_s);
   assign occ_nxt_s   = count_s + {{L{1'b0}}, wr_ok_s} - {{L{1'b0}}, rd_s};

   // Framing FSM: decides whether a beat is stored, dropped or restarts a TLP.
   always_comb begin
      wr_beat_s.data    = bus.tl_rx_data[C_PCI_DATA_WIDTH-1:0];
      wr_beat_s.sop     = bus.tl_rx_sop;
      wr_beat_s.eop     = bus.tl_rx_eop;
      wr_beat_s.end_off = mask_to_end_off(bus.tl_rx_valid);
      wr_beat_s.bardec  = bar_r;
      wr_beat_s.err     = err_acc_r | beat_err_s;
      wr_en_s       = 1'b0;
      mark_s        = 1'b0;
      stray_s       = 1'b0;
      restart_s     = 1'b0;
      state_nxt_s   = state_r;
      bar_nxt_s     = bar_r;
      err_acc_nxt_s = err_acc_r;
      if (beat_s) begin
         if (bus.tl_rx_sop) begin
            // A SOP always opens a fresh TLP; inside a packet it also closes the old one.
            wr_en_s          = 1'b1;
            wr_beat_s.bardec = bus.tl_rx_bardec;
            wr_beat_s.err    = beat_err_s;
            bar_nxt_s        = bus.tl_rx_bardec;
            err_acc_nxt_s    = beat_err_s;
            state_nxt_s      = bus.tl_rx_eop ? ST_IDLE : ST_IN_PKT;
            restart_s        = (state_r == ST_IN_PKT);
            mark_s           = restart_s;
         end else if (state_r == ST_IN_PKT) begin
            wr_en_s       = 1'b1;
            err_acc_nxt_s = err_acc_r | beat_err_s;
            state_nxt_s   = bus.tl_rx_eop ? ST_IDLE : ST_IN_PKT;
         end else begin
            stray_s = 1'b1;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state and per-TLP BAR / error context.
   always_ff @(posedge pcie_tl_clk or negedge pcie_tl_rst_n) begin
      if (!pcie_tl_rst_n) begin
         state_r   <= ST_IDLE;
         bar_r     <= 6'h00;
         err_acc_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         bar_r     <= bar_nxt_s;
         err_acc_r <= err_acc_nxt_s;
      end
   end

   // Saturating framing error counter.
   always_ff @(posedge pcie_tl_clk or negedge pcie_tl_rst_n) begin
      if (!pcie_tl_rst_n) begin
         proto_cnt_r <= 16'h0000;
      end else if (proto_sum_s[16]) begin
         proto_cnt_r <= 16'hFFFF;
      end else begin
         proto_cnt_r <= proto_sum_s[15:0];
      end
   end

   // Sticky overflow flag and registered backpressure from next-cycle occupancy.
   always_ff @(posedge pcie_tl_clk or negedge pcie_tl_rst_n) begin
      if (!pcie_tl_rst_n) begin
         overflow_r <= 1'b0;
         wait_r     <= 1'b1;
      end else begin
         overflow_r <= overflow_r | (wr_en_s & full_s & ~rd_s);
         wait_r     <= (occ_nxt_s >= WAIT_THRESH);
      end
   end

   gowin_tl_rx_adapter_fifo #(
      .WIDTH      ($bits(gowin_rx_beat_t)),
      .DEPTH_LOG2 (C_FIFO_DEPTH_LOG2),
      .MARK_BIT   (GOWIN_BEAT_EOP_BIT)
   ) u_fifo (
      .clk       (pcie_tl_clk),
      .rst_n     (pcie_tl_rst_n),
      .wr_en     (wr_en_s),
      .wr_data   (wr_beat_s),
      .mark_last (mark_s),
      .rd_en     (bus.rx_tlp_ready),
      .rd_data   (rd_beat_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s)
   );

   // RIFFA-side view of the FIFO head; everything reads zero while empty.
   always_comb begin
      bus.tl_rx_wait          = wait_r;
      bus.proto_err_cnt       = proto_cnt_r;
      bus.overflow            = overflow_r;
      bus.rx_tlp_valid        = ~empty_s;
      bus.rx_tlp_start_offset = 3'd0;
      if (empty_s) begin
         bus.rx_tlp            = '0;
         bus.rx_tlp_start_flag = 1'b0;
         bus.rx_tlp_end_flag   = 1'b0;
         bus.rx_tlp_end_offset = 3'd0;
         bus.rx_tlp_bar_decode = 6'h00;
         bus.rx_tlp_err        = 1'b0;
      end else begin
         bus.rx_tlp            = rd_beat_s.data;
         bus.rx_tlp_start_flag = rd_beat_s.sop;
         bus.rx_tlp_end_flag   = rd_beat_s.eop;
         bus.rx_tlp_end_offset = rd_beat_s.eop ? rd_beat_s.end_off : 3'd0;
         bus.rx_tlp_bar_decode = rd_beat_s.bardec;
         bus.rx_tlp_err        = rd_beat_s.eop & rd_beat_s.err;
      end
   end

endmodule

// File: tb/tb_gowin_tl_rx_adapter.sv
// Directed bench for gowin_tl_rx_adapter.
module tb_gowin_tl_rx_adapter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   gowin_tl_rx_adapter_if bus();

   gowin_tl_rx_adapter #(
      .C_PCI_DATA_WIDTH  (256),
      .C_FIFO_DEPTH_LOG2 (3),
      .C_RX_WAIT_LATENCY (2)
   ) dut (
      .pcie_tl_clk   (clk),
      .pcie_tl_rst_n (rst_n),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // {valid, start, start_off, end, end_off, bar, err}
   function automatic logic [15:0] obs_flags();
      return {bus.rx_tlp_valid, bus.rx_tlp_start_flag, bus.rx_tlp_start_offset,
              bus.rx_tlp_end_flag, bus.rx_tlp_end_offset, bus.rx_tlp_bar_decode, bus.rx_tlp_err};
   endfunction

   task automatic drive_beat(input logic sop, input logic eop, input logic [7:0] valid,
                             input logic [31:0] tag, input logic [5:0] bar, input logic [7:0] err);
      bus.tl_rx_sop    = sop;
      bus.tl_rx_eop    = eop;
      bus.tl_rx_valid  = valid;
      bus.tl_rx_data   = {8{tag}};
      bus.tl_rx_bardec = bar;
      bus.tl_rx_err    = err;
   endtask

   task automatic drive_idle();
      drive_beat(1'b0, 1'b0, 8'h00, 32'h0, 6'h00, 8'h00);
   endtask

   task automatic test_reset();
      #12;
      tests_run++;
      if (obs_flags() !== 16'h0000) begin tests_failed++; $display("FAIL reset_flags: got %h expected 0000", obs_flags()); end
      tests_run++;
      if ({bus.tl_rx_wait, bus.overflow, bus.proto_err_cnt} !== {1'b1, 1'b0, 16'h0000}) begin
         tests_failed++; $display("FAIL reset_status: got wait=%b ovf=%b cnt=%h expected 1 0 0000", bus.tl_rx_wait, bus.overflow, bus.proto_err_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (bus.tl_rx_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_wait_release: got %b expected 0", bus.tl_rx_wait); end
   endtask

   task automatic test_single_beat();
      bus.rx_tlp_ready = 1'b1;
      @(negedge clk) drive_beat(1'b1, 1'b1, 8'h0F, 32'h1111_1111, 6'h01, 8'h00);
      @(negedge clk) drive_idle();
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd3, 6'h01, 1'b0}) begin tests_failed++; $display("FAIL single_flags: got %h", obs_flags()); end
      tests_run++;
      if (bus.rx_tlp !== {8{32'h1111_1111}}) begin tests_failed++; $display("FAIL single_data: got %h expected 11111111 x8", bus.rx_tlp[31:0]); end
      @(negedge clk);
      tests_run++;
      if (bus.rx_tlp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained: got %b expected 0", bus.rx_tlp_valid); end
   endtask

   task automatic test_multi_beat();
      bus.rx_tlp_ready = 1'b1;
      @(negedge clk) drive_beat(1'b1, 1'b0, 8'hFF, 32'h2100_0001, 6'h02, 8'h00);
      @(negedge clk) drive_beat(1'b0, 1'b0, 8'hFF, 32'h2100_0002, 6'h00, 8'h04);
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 6'h02, 1'b0} || bus.rx_tlp !== {8{32'h2100_0001}}) begin
         tests_failed++; $display("FAIL multi_beat1: got %h data %h", obs_flags(), bus.rx_tlp[31:0]);
      end
      @(negedge clk) drive_beat(1'b0, 1'b1, 8'h07, 32'h2100_0003, 6'h00, 8'h00);
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 6'h02, 1'b0} || bus.rx_tlp !== {8{32'h2100_0002}}) begin
         tests_failed++; $display("FAIL multi_beat2: got %h data %h", obs_flags(), bus.rx_tlp[31:0]);
      end
      @(negedge clk) drive_idle();
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 6'h02, 1'b1} || bus.rx_tlp !== {8{32'h2100_0003}}) begin
         tests_failed++; $display("FAIL multi_beat3: got %h data %h", obs_flags(), bus.rx_tlp[31:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_wait_backpressure();
      int sent = 0;
      int after = 0;
      int sent_at_wait = -1;
      bus.rx_tlp_ready = 1'b0;
      for (int c = 0; c < 20 && after < 2; c++) begin
         @(negedge clk);
         if (bus.tl_rx_wait === 1'b1 && sent_at_wait < 0) sent_at_wait = sent;
         if (sent_at_wait >= 0) after++;
         drive_beat(1'b1, 1'b1, 8'h0F, 32'h0000_0300 + 32'(sent), 6'h07, 8'h00);
         sent++;
      end
      @(negedge clk) drive_idle();
      tests_run++;
      if (sent_at_wait !== 5) begin tests_failed++; $display("FAIL wait_rise_occ: got %0d expected 5", sent_at_wait); end
      @(negedge clk);
      tests_run++;
      if ({bus.overflow, bus.tl_rx_wait} !== 2'b01) begin tests_failed++; $display("FAIL wait_full_status: got ovf=%b wait=%b expected 0 1", bus.overflow, bus.tl_rx_wait); end
      bus.rx_tlp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tests_run++;
         if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd3, 6'h07, 1'b0} || bus.rx_tlp !== {8{32'h0000_0300 + 32'(i)}}) begin
            tests_failed++; $display("FAIL wait_drain%0d: got %h data %h expected tag %h", i, obs_flags(), bus.rx_tlp[31:0], 32'h0000_0300 + 32'(i));
         end
         @(negedge clk);
      end
      tests_run++;
      if ({bus.rx_tlp_valid, bus.tl_rx_wait, bus.overflow} !== 3'b000) begin
         tests_failed++; $display("FAIL wait_after_drain: got valid=%b wait=%b ovf=%b expected 0 0 0", bus.rx_tlp_valid, bus.tl_rx_wait, bus.overflow);
      end
   endtask

   task automatic test_framing();
      bus.rx_tlp_ready = 1'b0;
      @(negedge clk) drive_beat(1'b0, 1'b0, 8'hFF, 32'h4000_0000, 6'h09, 8'h00);
      @(negedge clk) drive_idle();
      tests_run++;
      if ({bus.proto_err_cnt, bus.rx_tlp_valid} !== {16'h0001, 1'b0}) begin
         tests_failed++; $display("FAIL stray_drop: got cnt=%h valid=%b expected 0001 0", bus.proto_err_cnt, bus.rx_tlp_valid);
      end
      @(negedge clk) drive_beat(1'b1, 1'b0, 8'hFF, 32'h4100_0000, 6'h03, 8'h00);
      @(negedge clk) drive_beat(1'b1, 1'b1, 8'h0F, 32'h4200_0000, 6'h04, 8'h00);
      @(negedge clk) drive_idle();
      tests_run++;
      if (bus.proto_err_cnt !== 16'h0002) begin tests_failed++; $display("FAIL restart_cnt: got %h expected 0002", bus.proto_err_cnt); end
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd7, 6'h03, 1'b0} || bus.rx_tlp !== {8{32'h4100_0000}}) begin
         tests_failed++; $display("FAIL forced_end: got %h data %h", obs_flags(), bus.rx_tlp[31:0]);
      end
      bus.rx_tlp_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd3, 6'h04, 1'b0} || bus.rx_tlp !== {8{32'h4200_0000}}) begin
         tests_failed++; $display("FAIL restart_tlp: got %h data %h", obs_flags(), bus.rx_tlp[31:0]);
      end
      @(negedge clk) drive_beat(1'b1, 1'b1, 8'h05, 32'h4300_0000, 6'h06, 8'h00);
      @(negedge clk) drive_idle();
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd2, 6'h06, 1'b0} || bus.proto_err_cnt !== 16'h0003) begin
         tests_failed++; $display("FAIL noncontig: got %h cnt %h expected cnt 0003", obs_flags(), bus.proto_err_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      bus.rx_tlp_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk) drive_beat(1'b1, 1'b1, 8'h01, 32'h0000_0500 + 32'(i), 6'h08, 8'h00);
      end
      @(negedge clk) drive_idle();
      tests_run++;
      if ({bus.overflow, bus.tl_rx_wait} !== 2'b11) begin tests_failed++; $display("FAIL overflow_set: got ovf=%b wait=%b expected 1 1", bus.overflow, bus.tl_rx_wait); end
      bus.rx_tlp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 6'h08, 1'b0} || bus.rx_tlp !== {8{32'h0000_0500 + 32'(i)}}) begin
            tests_failed++; $display("FAIL overflow_drain%0d: got %h data %h expected tag %h", i, obs_flags(), bus.rx_tlp[31:0], 32'h0000_0500 + 32'(i));
         end
         @(negedge clk);
      end
      tests_run++;
      if ({bus.rx_tlp_valid, bus.overflow} !== 2'b01) begin tests_failed++; $display("FAIL overflow_sticky: got valid=%b ovf=%b expected 0 1", bus.rx_tlp_valid, bus.overflow); end
   endtask

   task automatic test_reset_mid_packet();
      bus.rx_tlp_ready = 1'b0;
      @(negedge clk) drive_beat(1'b1, 1'b0, 8'hFF, 32'h6100_0000, 6'h05, 8'h00);
      @(negedge clk) drive_idle();
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (obs_flags() !== 16'h0000) begin tests_failed++; $display("FAIL midrst_flags: got %h expected 0000", obs_flags()); end
      tests_run++;
      if ({bus.tl_rx_wait, bus.overflow, bus.proto_err_cnt} !== {1'b1, 1'b0, 16'h0000}) begin
         tests_failed++; $display("FAIL midrst_status: got wait=%b ovf=%b cnt=%h expected 1 0 0000", bus.tl_rx_wait, bus.overflow, bus.proto_err_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      bus.rx_tlp_ready = 1'b1;
      @(negedge clk) drive_beat(1'b1, 1'b1, 8'h01, 32'h6A00_0000, 6'h05, 8'h00);
      @(negedge clk) drive_idle();
      tests_run++;
      if (obs_flags() !== {1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 6'h05, 1'b0} || bus.rx_tlp !== {8{32'h6A00_0000}} || bus.proto_err_cnt !== 16'h0000) begin
         tests_failed++; $display("FAIL post_reset_tlp: got %h data %h cnt %h", obs_flags(), bus.rx_tlp[31:0], bus.proto_err_cnt);
      end
      @(negedge clk);
      tests_run++;
      if (bus.rx_tlp_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_drain: got %b expected 0", bus.rx_tlp_valid); end
   endtask

   initial begin
      drive_idle();
      bus.rx_tlp_ready = 1'b0;
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_wait_backpressure();
      test_framing();
      test_overflow();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
